// File: rtl/time_set_pkg.sv
// Shared types and constants for front-panel time setting: edit states, field codes,
// BCD limits, the time-word layout used by the HH:MM clock, and BCD step helpers.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // {HT,HO,MT,MO,ST,SO}
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)             r = 8'h00;
    else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
    else                      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00)           r = max;
    else if (v[3:0] == 4'h0)  r = {v[7:4] - 4'h1, 4'h9};
    else                      r = {v[7:4], v[3:0] - 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop sync -> stability counter; registered press pulse on debounced rise
// and optional auto-repeat while held. Press appears 2 + DebounceCycles cycles after a clean edge.
module button_debouncer #(
  parameter int DebounceCycles = 10000,
  parameter int RepeatDelay    = 500000,
  parameter int RepeatPeriod   = 100000,
  parameter bit RepeatEn       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic rep_restart,
  output logic press,
  output logic rep
);

  localparam int DbW = $clog2(DebounceCycles + 1);
  localparam int RpW = $clog2(RepeatDelay + 1);
  localparam logic [DbW-1:0] DB_LAST   = DbW'(DebounceCycles - 1);
  localparam logic [RpW-1:0] RP_LAST   = RpW'(RepeatDelay - 1);
  localparam logic [RpW-1:0] RP_RELOAD = RpW'(RepeatDelay - RepeatPeriod);

  logic           sync1_q, sync2_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           armed_q, armed_d;
  logic           held_q, held_d;
  logic           press_q, press_d;
  logic [RpW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_q, rep_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) level_d  = sync2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end

    // A press only counts once the button has been seen released since reset.
    armed_d = armed_q | ~sync2_q;
    press_d = armed_q & level_d & ~level_q;
    held_d  = level_d & (held_q | press_d);

    rep_cnt_d = '0;
    rep_d     = 1'b0;
    if (RepeatEn && held_q && level_d && !rep_restart) begin
      if (rep_cnt_q == RP_LAST) begin
        rep_d     = 1'b1;
        rep_cnt_d = RP_RELOAD;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Sync flops come out of reset high so a button held through reset looks already pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      armed_q   <= 1'b0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      armed_q   <= armed_d;
      held_q    <= held_d;
      press_q   <= press_d;
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign press = press_q;
  assign rep   = rep_q;

endmodule

// File: rtl/time_set_entry.sv
// Front-panel HH:MM edit FSM: debounced mode/inc/dec buttons step BCD hours then minutes and
// issue a one-cycle load with setTime; edits abort after TimeoutSecs idle. All outputs registered.
module time_set_entry
  import time_set_pkg::*;
#(
  parameter int CyclesPerSec   = 1000000,
  parameter int DebounceCycles = 10000,
  parameter int RepeatDelay    = 500000,
  parameter int RepeatPeriod   = 100000,
  parameter int TimeoutSecs    = 30
) (
  input  logic        clock_1MHz,
  input  logic        reset_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] currentTime,
  output logic [23:0] setTime,
  output logic        load,
  output logic        editing,
  output logic [1:0]  editField,
  output logic        blinkOn
);

  localparam int TickW  = $clog2(CyclesPerSec);
  localparam int SecW   = $clog2(TimeoutSecs + 1);
  localparam int BlinkW = $clog2(CyclesPerSec / 4);
  localparam logic [TickW-1:0]  TICK_LAST  = TickW'(CyclesPerSec - 1);
  localparam logic [SecW-1:0]   SEC_TO     = SecW'(TimeoutSecs);
  localparam logic [BlinkW-1:0] BLINK_LAST = BlinkW'(CyclesPerSec / 4 - 1);

  logic mode_press, mode_rep_unused, inc_press, inc_rep, dec_press, dec_rep;
  logic mode_ev, inc_ev, dec_ev, any_ev, step_up, step_dn, rep_restart, timeout, edit_next;
  logic unused_sec;

  state_e              state_q, state_d;
  logic [7:0]          hour_q, hour_d, min_q, min_d;
  logic [23:0]         set_time_q, set_time_d;
  logic                load_q, load_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [SecW-1:0]     sec_q, sec_d;
  logic                blink_q, blink_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;

  button_debouncer #(.DebounceCycles(DebounceCycles), .RepeatDelay(RepeatDelay),
                     .RepeatPeriod(RepeatPeriod), .RepeatEn(1'b0)) u_mode (
    .clk(clock_1MHz), .rst_n(reset_n), .btn_raw(btn_mode), .rep_restart(1'b0),
    .press(mode_press), .rep(mode_rep_unused));

  button_debouncer #(.DebounceCycles(DebounceCycles), .RepeatDelay(RepeatDelay),
                     .RepeatPeriod(RepeatPeriod), .RepeatEn(1'b1)) u_inc (
    .clk(clock_1MHz), .rst_n(reset_n), .btn_raw(btn_inc), .rep_restart(rep_restart),
    .press(inc_press), .rep(inc_rep));

  button_debouncer #(.DebounceCycles(DebounceCycles), .RepeatDelay(RepeatDelay),
                     .RepeatPeriod(RepeatPeriod), .RepeatEn(1'b1)) u_dec (
    .clk(clock_1MHz), .rst_n(reset_n), .btn_raw(btn_dec), .rep_restart(rep_restart),
    .press(dec_press), .rep(dec_rep));

  assign mode_ev     = mode_press;
  assign inc_ev      = inc_press | inc_rep;
  assign dec_ev      = dec_press | dec_rep;
  assign any_ev      = mode_ev | inc_ev | dec_ev;
  assign step_up     = inc_ev & ~dec_ev;
  assign step_dn     = dec_ev & ~inc_ev;
  assign rep_restart = mode_ev & (inc_ev | dec_ev);
  assign timeout     = (sec_q == SEC_TO);
  assign unused_sec  = ^currentTime[SEC_LSB +: 8];

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    set_time_d  = set_time_q;
    load_d      = 1'b0;
    tick_d      = tick_q;
    sec_d       = sec_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    // Mode beats a same-cycle step; timeout beats everything.
    case (state_q)
      IDLE: begin
        if (mode_ev) begin
          hour_d  = currentTime[HOUR_LSB +: 8];
          min_d   = currentTime[MIN_LSB +: 8];
          state_d = EDIT_HOUR;
        end
      end
      EDIT_HOUR: begin
        if (timeout)      state_d = IDLE;
        else if (mode_ev) state_d = EDIT_MIN;
        else if (step_up) hour_d  = bcd_inc(hour_q, HOUR_MAX);
        else if (step_dn) hour_d  = bcd_dec(hour_q, HOUR_MAX);
      end
      EDIT_MIN: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (mode_ev) begin
          state_d    = COMMIT;
          load_d     = 1'b1;
          set_time_d = {hour_q, min_q, 8'h00};
        end else if (step_up) begin
          min_d = bcd_inc(min_q, MIN_MAX);
        end else if (step_dn) begin
          min_d = bcd_dec(min_q, MIN_MAX);
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    edit_next = (state_d == EDIT_HOUR) || (state_d == EDIT_MIN);

    if (!edit_next || any_ev) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      sec_d  = sec_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    // Blink phase restarts lit whenever a new field becomes active.
    if (!edit_next) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_1MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      set_time_q  <= 24'h000000;
      load_q      <= 1'b0;
      tick_q      <= '0;
      sec_q       <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      set_time_q  <= set_time_d;
      load_q      <= load_d;
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign setTime   = set_time_q;
  assign load      = load_q;
  assign editing   = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);
  assign editField = (state_q == EDIT_HOUR) ? FIELD_HOUR :
                     (state_q == EDIT_MIN)  ? FIELD_MIN  : FIELD_NONE;
  assign blinkOn   = blink_q;

endmodule

// File: tb/tb_time_set_entry.sv
// Scoreboard bench for time_set_entry: expected setTime words queued as edits are driven,
// popped and compared on every load pulse.
module tb_time_set_entry;

  localparam int CPS = 100;
  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int TO  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_mode = 1'b0, b_inc = 1'b0, b_dec = 1'b0;
  logic [23:0] cur_time = 24'h0;
  logic [23:0] set_time;
  logic        load, editing, blink_on;
  logic [1:0]  edit_field;

  logic [23:0] sb_q[$];
  int          n_vec = 0, n_err = 0, load_cnt = 0, cyc = 0;

  time_set_entry #(
    .CyclesPerSec(CPS), .DebounceCycles(DB), .RepeatDelay(RD),
    .RepeatPeriod(RP), .TimeoutSecs(TO)
  ) dut (
    .clock_1MHz(clk), .reset_n(rst_n), .btn_mode(b_mode), .btn_inc(b_inc), .btn_dec(b_dec),
    .currentTime(cur_time), .setTime(set_time), .load(load), .editing(editing),
    .editField(edit_field), .blinkOn(blink_on)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       b_mode = v;
      1:       b_inc  = v;
      default: b_dec  = v;
    endcase
  endtask

  // 12-cycle hold: long enough to debounce, shorter than the repeat delay.
  task automatic press_btn(input int which);
    set_btn(which, 1'b1);
    repeat (12) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      if (sb_q.size() == 0) chk("load_unexpected", {23'b0, load}, 24'h0);
      else                  chk("set_time_at_load", set_time, sb_q.pop_front());
    end
  end

  initial begin
    int h, m, k, t0, el;
    logic [23:0] last_commit;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_set_time", set_time, 24'h0);
    chk("rst_load", {23'b0, load}, 24'h0);
    chk("rst_editing", {23'b0, editing}, 24'h0);
    chk("rst_field", {22'b0, edit_field}, 24'h0);
    chk("rst_blink", {23'b0, blink_on}, 24'h0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_set_time", set_time, 24'h0);
    chk("idle_editing", {23'b0, editing}, 24'h0);

    // Hour wrap up, minute step down
    cur_time = 24'h235930; h = 23; m = 59;
    press_btn(0);
    chk("enter_editing", {23'b0, editing}, 24'h1);
    chk("enter_field", {22'b0, edit_field}, 24'h1);
    press_btn(1); h = (h + 1) % 24;
    press_btn(0);
    chk("min_field", {22'b0, edit_field}, 24'h2);
    press_btn(2); m = (m + 59) % 60;
    last_commit = {to_bcd(h), to_bcd(m), 8'h00};
    sb_q.push_back(last_commit);
    press_btn(0);
    chk("post_commit_editing", {23'b0, editing}, 24'h0);
    chk("post_commit_hold", set_time, last_commit);

    // Bouncing inc then a long hold: one press plus two repeats
    cur_time = 24'h125700; h = 12; m = 57;
    press_btn(0);
    press_btn(0);
    chk("bounce_field", {22'b0, edit_field}, 24'h2);
    for (int i = 0; i < 10; i++) begin
      b_inc = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    b_inc = 1'b1;
    repeat (30) @(negedge clk);
    b_inc = 1'b0;
    repeat (12) @(negedge clk);
    m = (m + 3) % 60;
    last_commit = {to_bcd(h), to_bcd(m), 8'h00};
    sb_q.push_back(last_commit);
    press_btn(0);

    // Simultaneous inc+dec, then mode together with inc
    cur_time = 24'h104500; h = 10; m = 45;
    press_btn(0);
    b_inc = 1'b1; b_dec = 1'b1;
    repeat (12) @(negedge clk);
    b_inc = 1'b0; b_dec = 1'b0;
    repeat (12) @(negedge clk);
    chk("incdec_field", {22'b0, edit_field}, 24'h1);
    b_mode = 1'b1; b_inc = 1'b1;
    repeat (12) @(negedge clk);
    b_mode = 1'b0; b_inc = 1'b0;
    repeat (12) @(negedge clk);
    chk("mode_wins_field", {22'b0, edit_field}, 24'h2);
    last_commit = {to_bcd(h), to_bcd(m), 8'h00};
    sb_q.push_back(last_commit);
    press_btn(0);

    // Blink phase on entry, then timeout abort
    t0 = cyc;
    b_mode = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = editing;
    end
    chk("to_enter", {23'b0, editing}, 24'h1);
    chk("to_blink_start", {23'b0, blink_on}, 24'h1);
    chk("to_field", {22'b0, edit_field}, 24'h1);
    k = 0;
    while (blink_on === 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("blink_half_period", 24'(k), 24'd25);
    b_mode = 1'b0;
    for (int i = 0; i < 400 && editing === 1'b1; i++) @(negedge clk);
    el = cyc - t0;
    chk("to_fall", {23'b0, editing}, 24'h0);
    chk("to_not_early", {23'b0, (el < 300)}, 24'h0);
    chk("to_not_late", {23'b0, (el > 316)}, 24'h0);
    chk("to_set_time_kept", set_time, last_commit);

    // Asynchronous reset mid-edit with mode held through release
    cur_time = 24'h081500;
    press_btn(0);
    press_btn(0);
    chk("rst_pre_field", {22'b0, edit_field}, 24'h2);
    b_mode = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_editing", {23'b0, editing}, 24'h0);
    chk("arst_field", {22'b0, edit_field}, 24'h0);
    chk("arst_blink", {23'b0, blink_on}, 24'h0);
    chk("arst_load", {23'b0, load}, 24'h0);
    chk("arst_set_time", set_time, 24'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("held_thru_rst", {23'b0, editing}, 24'h0);
    b_mode = 1'b0;
    repeat (12) @(negedge clk);
    press_btn(0);
    chk("repress_after_rst", {23'b0, editing}, 24'h1);

    chk("sb_drained", 24'(sb_q.size()), 24'h0);
    chk("load_count", 24'(load_cnt), 24'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_entry.md
# time_set_entry

Front-panel time-setting block that writes the 24-bit BCD `setTime` word and a one-cycle `load` strobe consumed by the HH:MM 24-hour clock. It debounces three raw push-buttons (mode, increment, decrement). A small edit state machine lets the user adjust hours and then minutes with wrap-around and auto-repeat, and exposes field/blink status for the seven-segment display path.

## Interface
Parameters:
- `CyclesPerSec`, 1000000: clock cycles per second.
- `DebounceCycles`, 10000: cycles a synchronized button must be stable before its debounced level changes.
- `RepeatDelay`, 500000: hold time before the first auto-repeat.
- `RepeatPeriod`, 100000: cycles between subsequent auto-repeats.
- `TimeoutSecs`, 30: seconds without a button event before edit is aborted.

Ports:
- `clock_1MHz` in 1: sole clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `btn_mode`, `btn_inc`, `btn_dec` in 1 each: raw, asynchronous, active-high buttons.
- `currentTime` in 24: live BCD time {HT,HO,MT,MO,ST,SO}, captured on edit entry.
- `setTime` out 24: BCD time word to the clock.
- `load` out 1: one-cycle strobe; `setTime` is valid while high.
- `editing` out 1: high in EDIT_HOUR/EDIT_MIN.
- `editField` out 2: 0 none, 1 hours, 2 minutes.
- `blinkOn` out 1: 2 Hz, 50% duty phase for the field being edited; 0 when not editing.

## Operation
- Each button: 2-flop synchronizer, then counter debounce. `press` is a one-cycle pulse on the debounced 0->1 edge. `rep` pulses after `RepeatDelay` of continuous hold, then every `RepeatPeriod`; repeat applies to inc/dec only.
- States: IDLE -> EDIT_HOUR -> EDIT_MIN -> COMMIT -> IDLE.
- IDLE + mode press: capture `currentTime[23:8]` into hour/min shadow registers, go EDIT_HOUR. Other buttons are ignored.
- EDIT_HOUR: inc/dec (press or rep) steps hours 00..23 in BCD. 23+1 -> 00, 00-1 -> 23. Mode press -> EDIT_MIN.
- EDIT_MIN: steps minutes 00..59 in BCD. 59+1 -> 00, 00-1 -> 59. Hours are not carried. Mode press -> COMMIT.
- COMMIT: lasts exactly 1 cycle. `setTime` = {hours, minutes, 8'h00}, `load`=1, then IDLE.
- BCD rule: ones digit 9 -> 0 with tens+1; ones 0 with dec -> 9 with tens-1. Fields are never outside the legal range.
- Simultaneous inc and dec events in one cycle: no change.
- Mode event in the same cycle as inc/dec: mode wins, the step is discarded, and the repeat counters restart.
- Timeout: a seconds counter clears on any press. Reaching `TimeoutSecs` in EDIT_* returns to IDLE with no `load`; `setTime` is unchanged.
- `setTime` holds its last committed value between commits.
- `blinkOn` toggles every `CyclesPerSec/4` cycles and restarts at 1 on edit entry and on each field change.

## Timing
- Reset values: `setTime`=24'h000000, `load`=0, `editing`=0, `editField`=0, `blinkOn`=0, state IDLE, debounced levels 0, all counters 0.
- Button to press pulse: 2 sync cycles + `DebounceCycles` stable cycles. Shadow-register updates and state changes happen on the clock edge after the pulse.
- The mode press that leaves EDIT_MIN is followed by COMMIT on the next edge. `load` is high for that single cycle.
- `reset_n` low mid-edit: immediate return to IDLE with reset values. No `load` is issued. Shadow values are lost.
- A button held through reset release produces no press until it is released and pressed again; the debounced level powers up at 0 and sees a stable 1.
- Registered outputs only; no combinational path from buttons to outputs.

## Structure
- Shared package `time_set_pkg`: state enum (IDLE, EDIT_HOUR, EDIT_MIN, COMMIT), `editField` encodings, BCD limit constants (hour max 8'h23, minute max 8'h59), and the 24-bit time-word field offsets shared with the clock.
- Sub-module `button_debouncer`, instantiated three times: synchronizer, debounce counter, press pulse, and an optional repeat generator enabled by parameter.
- Top level: FSM, BCD up/down step logic, timeout counter, blink counter.

## Test plan
Simulate with `CyclesPerSec`=100, `DebounceCycles`=4, `RepeatDelay`=20, `RepeatPeriod`=5, `TimeoutSecs`=3.
- Reset, then no stimulus -> `setTime`=000000, `load` never asserts, `editing`=0.
- `currentTime`=235930; press mode, inc, mode, dec, mode -> one `load` pulse with `setTime`=0058_00 (hour 23+1 wraps to 00; minute 59-1 = 58).
- `btn_inc` bounces 0/1 every 2 cycles for 20 cycles, then holds 1 for 30 cycles, in EDIT_MIN starting at 57 -> exactly 1 press plus repeats after 20 and 25 cycles of hold; minutes reach 00 via 58, 59, 00.
- Inc and dec asserted together in EDIT_HOUR at 10 -> hours stay 10; mode pressed in the same cycle as inc -> field advances to minutes and hours stay 10.
- Enter edit, then idle for 3 s (300 cycles) -> `editing` falls, no `load`, `setTime` keeps its previous value.
- Drop `reset_n` in EDIT_MIN -> asynchronous return to reset values with no `load`; `btn_mode` held across reset release gives no press until it is re-pressed.
